burst_randomizer_ctrl: RTL and testbench

Burst-level sequencer for the PHY bit randomizer. It accepts a burst command with a bit length, reloads the PRBS generator with the configured seed at the start of every burst, and steps it once per accepted data bit. Each bit is XORed with the PRBS output and forwarded downstream with valid/ready flow control. The block sits between the FEC-input bit source and the encoder.

---
 rtl/burst_randomizer_ctrl.sv | 145 ++++++++++++++
 tb/tb_burst_randomizer_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_randomizer_ctrl.sv
// Burst sequencer for the PHY bit randomizer: per-burst PRBS reseed, one-cycle bit latency.
// s_ready is low outside RUN and whenever a held output bit is stalled by m_ready.
module burst_randomizer_ctrl #(
  parameter logic [15:1] SEED  = 15'h3715,
  parameter int          LEN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_seed_we,
  input  logic [15:1]      cfg_seed,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic             m_data,
  output logic             m_last,
  input  logic             m_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [15:1]      lfsr_q, lfsr_d;
  logic [15:1]      seed_q, seed_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic             m_data_q, m_data_d;
  logic             m_last_q, m_last_d;

  logic             prbs_bit;
  logic             s_xfer;
  logic             last_bit;

  assign prbs_bit = lfsr_q[2] ^ lfsr_q[1];
  assign last_bit = (cnt_q == LEN_W'(1));

  // A new bit may enter only if the output register is empty or draining this cycle.
  assign s_ready  = (state_q == S_RUN) && (!m_valid_q || m_ready);
  assign s_xfer   = s_valid && s_ready;

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      seed_q    <= SEED;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      seed_q    <= seed_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    seed_d    = seed_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;

    case (state_q)
      S_IDLE: begin
        // The seed written alongside start is already visible when LOAD copies it.
        if (cfg_seed_we) begin
          seed_d = cfg_seed;
        end
        if (start) begin
          cnt_d   = burst_len;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        lfsr_d  = seed_q;
        state_d = (cnt_q == '0) ? S_DONE : S_RUN;
      end

      S_RUN: begin
        if (s_xfer) begin
          m_data_d  = s_data ^ prbs_bit;
          m_valid_d = 1'b1;
          m_last_d  = last_bit;
          lfsr_d    = {prbs_bit, lfsr_q[15:2]};
          cnt_d     = cnt_q - LEN_W'(1);
          if (last_bit) begin
            state_d = S_DRAIN;
          end
        end else if (m_ready) begin
          m_valid_d = 1'b0;
        end
      end

      S_DRAIN: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every transition; the LFSR keeps its value until the next LOAD.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      cnt_d     = '0;
    end
  end

endmodule

// File: tb/tb_burst_randomizer_ctrl.sv
// Random and directed stimulus for burst_randomizer_ctrl, checked every cycle against a burst-level model.
`timescale 1ns/1ps
module tb_burst_randomizer_ctrl;
  localparam int          LEN_W = 12;
  localparam logic [15:1] SEED  = 15'h3715;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_seed_we = 1'b0;
  logic [15:1]      cfg_seed = '0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             abort = 1'b0;
  logic             busy, done;
  logic             s_valid = 1'b0;
  logic             s_data = 1'b0;
  logic             s_ready;
  logic             m_valid, m_data, m_last;
  logic             m_ready = 1'b0;

  burst_randomizer_ctrl #(.SEED(SEED), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cfg_seed_we(cfg_seed_we), .cfg_seed(cfg_seed),
    .start(start), .burst_len(burst_len), .abort(abort), .busy(busy), .done(done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: phase 0 idle, 1 load, 2 run, 3 drain, 4 done; keystream indexed per burst.
  int          ph;
  int          left;
  int          k;
  logic [15:1] mseed, bseed;
  logic        mv, md, ml;

  logic [63:0] cap, lastcap;
  int          ncap, nxfer, ndone, nmv, done_cyc, start_cyc;
  logic        stall_prev, stall_md;
  bit          busy_cfg = 1'b0;

  // Keystream bit k from the LFSR recurrence b[n+15] = b[n] ^ b[n+1], bits b[1..15] = seed.
  function automatic logic ks(input logic [15:1] sd, input int kk);
    logic b [1:80];
    for (int i = 1; i <= 15; i++) b[i] = sd[i];
    for (int n = 1; n <= 65; n++) b[n+15] = b[n] ^ b[n+1];
    return b[kk+1] ^ b[kk+2];
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; left = 0; k = 0; mseed = SEED; bseed = SEED;
    mv = 1'b0; md = 1'b0; ml = 1'b0;
  endtask

  // One clock: compare at negedge, advance the model across the posedge, return at posedge+1.
  task automatic step();
    logic exp_srdy;
    logic xfer;
    @(negedge clk);
    exp_srdy = (ph == 2) && (!mv || m_ready);
    chk("busy", busy, ph != 0);
    chk("done", done, ph == 4);
    chk("s_ready", s_ready, exp_srdy);
    chk("m_valid", m_valid, mv);
    chk("m_last", m_last, ml);
    if (mv) chk("m_data", m_data, md);
    if (stall_prev) chk("stall_hold", m_data, stall_md);
    stall_prev = m_valid && !m_ready && !reset && !abort;
    stall_md   = m_data;
    if (m_valid && m_ready) begin
      cap = {cap[62:0], m_data};
      lastcap = {lastcap[62:0], m_last};
      ncap++;
    end
    if (m_valid) nmv++;
    if (s_valid && s_ready) nxfer++;
    if (done) begin ndone++; done_cyc = cyc; end

    xfer = exp_srdy && s_valid;
    if (reset) begin
      model_reset();
      stall_prev = 1'b0;
    end else if (abort && ph != 0) begin
      ph = 0; mv = 1'b0; ml = 1'b0; left = 0;
    end else begin
      case (ph)
        0: begin
          if (cfg_seed_we) mseed = cfg_seed;
          if (start) begin left = int'(burst_len); ph = 1; end
        end
        1: begin
          bseed = mseed; k = 0;
          ph = (left == 0) ? 4 : 2;
        end
        2: begin
          if (xfer) begin
            md = s_data ^ ks(bseed, k);
            k++;
            mv = 1'b1;
            ml = (left == 1);
            if (left == 1) ph = 3;
            left--;
          end else if (m_ready) begin
            mv = 1'b0;
          end
        end
        3: begin
          if (mv && m_ready) begin mv = 1'b0; ml = 1'b0; ph = 4; end
        end
        default: ph = 0;
      endcase
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // rmode 0: m_ready held high; rmode 1: m_ready pattern 1,0,0 repeating.
  task automatic run_burst(input int len, input logic sd, input int rmode, input int abort_after);
    int nd0;
    cap = '0; lastcap = '0; ncap = 0; nxfer = 0; nmv = 0;
    nd0 = ndone;
    start = 1'b1; burst_len = LEN_W'(len); s_valid = 1'b1; s_data = sd; m_ready = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rmode == 1) m_ready = (i % 3 == 0);
      if (busy_cfg) begin cfg_seed_we = 1'b1; cfg_seed = 15'h7FFF; end
      if (abort_after > 0 && nxfer == abort_after) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        m_ready = 1'b1;
        return;
      end
      step();
      if (ndone != nd0) begin
        cfg_seed_we = 1'b0;
        m_ready = 1'b1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL burst_timeout len=%0d got=no_done exp=done", len);
    cfg_seed_we = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pin;
    int nd_a;
    bit fin;

    ndone = 0; stall_prev = 1'b0; cap = '0; lastcap = '0;
    model_reset();

    pin = '0;
    for (int i = 0; i < 8; i++) pin = {pin[6:0], ks(15'h3715, i)};
    chk8("model_pin_default", pin, 8'b11111001);
    pin = '0;
    for (int i = 0; i < 8; i++) pin = {pin[6:0], ks(15'h7FFF, i)};
    chk8("model_pin_ones", pin, 8'b00000000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    reset = 1'b0;
    step();

    // Default seed, zeros then ones.
    nd_a = ndone;
    run_burst(8, 1'b0, 0, 0);
    chk8("zeros_data", cap[7:0], 8'b11111001);
    chk8("zeros_last", lastcap[7:0], 8'b00000001);
    chk_int("zeros_done_cyc", done_cyc - start_cyc, 11);
    chk_int("zeros_done_cnt", ndone - nd_a, 1);
    step();
    run_burst(8, 1'b1, 0, 0);
    chk8("ones_data", cap[7:0], 8'b00000110);

    // Back-to-back: start presented in the IDLE cycle right after DONE.
    run_burst(8, 1'b0, 0, 0);
    chk8("b2b_first", cap[7:0], 8'b11111001);
    run_burst(8, 1'b0, 0, 0);
    chk8("b2b_second", cap[7:0], 8'b11111001);
    chk_int("b2b_done_cyc", done_cyc - start_cyc, 11);

    // Backpressure.
    step();
    nd_a = ndone;
    run_burst(8, 1'b0, 1, 0);
    chk8("bp_data", cap[7:0], 8'b11111001);
    chk_int("bp_done_cnt", ndone - nd_a, 1);

    // Abort after 3 bits, then a fresh burst.
    step();
    nd_a = ndone;
    run_burst(8, 1'b0, 0, 3);
    chk("abort_busy", busy, 1'b0);
    chk("abort_m_valid", m_valid, 1'b0);
    step(); step();
    chk_int("abort_no_done", ndone - nd_a, 0);
    run_burst(8, 1'b0, 0, 0);
    chk8("after_abort_data", cap[7:0], 8'b11111001);

    // Seed write in IDLE, then seed write attempted while busy.
    step();
    cfg_seed_we = 1'b1; cfg_seed = 15'h7FFF;
    step();
    cfg_seed_we = 1'b0;
    run_burst(8, 1'b0, 0, 0);
    chk8("seed_ones_data", cap[7:0], 8'b00000000);
    step();
    cfg_seed_we = 1'b1; cfg_seed = SEED;
    step();
    cfg_seed_we = 1'b0;
    busy_cfg = 1'b1;
    run_burst(8, 1'b0, 0, 0);
    busy_cfg = 1'b0;
    chk8("seed_busy_data", cap[7:0], 8'b11111001);
    step();
    run_burst(8, 1'b0, 0, 0);
    chk8("seed_busy_after", cap[7:0], 8'b11111001);

    // Zero-length burst.
    step();
    run_burst(0, 1'b0, 0, 0);
    chk_int("zero_done_cyc", done_cyc - start_cyc, 2);
    chk_int("zero_mvalid", nmv, 0);
    step();

    // Randomized bursts with stalls, aborts, ignored commands and mid-burst reset.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_seed_we = 1'b1; cfg_seed = 15'($urandom);
        step();
        cfg_seed_we = 1'b0;
      end
      start = 1'b1; burst_len = LEN_W'($urandom_range(0, 20));
      s_valid = $urandom_range(0, 1); s_data = $urandom_range(0, 1);
      step();
      start = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 400 && !fin; i++) begin
        s_valid     = $urandom_range(0, 1);
        s_data      = $urandom_range(0, 1);
        m_ready     = ($urandom_range(0, 3) != 0);
        cfg_seed_we = ($urandom_range(0, 7) == 0);
        cfg_seed    = 15'($urandom);
        start       = ($urandom_range(0, 7) == 0);
        burst_len   = LEN_W'($urandom);
        abort       = ($urandom_range(0, 60) == 0);
        reset       = ($urandom_range(0, 150) == 0);
        step();
        if (ph == 0) fin = 1'b1;
      end
      start = 1'b0; abort = 1'b0; reset = 1'b0; cfg_seed_we = 1'b0;
      if (!fin) begin
        checks++; errors++;
        $display("FAIL random_timeout t=%0d got=busy exp=idle", t);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
